// File: rtl/bin2bcd_seq_pkg.sv
// Shared constants and FSM state type for the sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;

  localparam int unsigned BcdW    = 4;
  localparam int unsigned NBcdNib = 5;
  localparam int unsigned MaxDec  = 9999;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

endpackage

// File: rtl/bcd_adj3.sv
// Double-dabble nibble correction: add 3 when the BCD nibble is 5 or more.
module bcd_adj3
  import bin2bcd_seq_pkg::*;
(
  input  logic [BcdW-1:0] nib_i,
  output logic [BcdW-1:0] nib_o
);

  always_comb begin
    nib_o = nib_i;
    if (nib_i >= BcdW'(5)) begin
      nib_o = nib_i + BcdW'(3);
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per clock,
// with start/busy/done handshake and saturating, registered digit outputs.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int unsigned BIN_W   = 14,
  parameter int unsigned MAX_DEC = MaxDec
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [BIN_W-1:0] value_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             ovf_o,
  output logic [BcdW-1:0]  digit1_o,
  output logic [BcdW-1:0]  digit2_o,
  output logic [BcdW-1:0]  digit3_o,
  output logic [BcdW-1:0]  digit4_o
);

  localparam int unsigned SrW  = NBcdNib * BcdW + BIN_W;
  localparam int unsigned CntW = $clog2(BIN_W);

  state_e                     state_q;
  logic [SrW-1:0]             sr_q;
  logic [SrW-1:0]             sr_adj;
  logic [CntW-1:0]            cnt_q;
  logic                       sat_q;
  logic                       done_q;
  logic                       ovf_q;
  logic [3:0][BcdW-1:0]       dig_q;

  // Binary part passes through; each BCD nibble above it is corrected before the shift.
  assign sr_adj[BIN_W-1:0] = sr_q[BIN_W-1:0];

  for (genvar g = 0; g < NBcdNib; g++) begin : gen_adj
    bcd_adj3 u_adj (
      .nib_i (sr_q[BIN_W + g*BcdW +: BcdW]),
      .nib_o (sr_adj[BIN_W + g*BcdW +: BcdW])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sr_q    <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dig_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            sr_q    <= SrW'(value_i);
            cnt_q   <= '0;
            sat_q   <= (32'(value_i) > MAX_DEC);
            state_q <= StShift;
          end
        end
        StShift: begin
          sr_q  <= sr_adj << 1;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(BIN_W - 1)) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          done_q <= 1'b1;
          ovf_q  <= sat_q;
          for (int i = 0; i < 4; i++) begin
            dig_q[i] <= sat_q ? BcdW'(9) : sr_q[BIN_W + i*BcdW +: BcdW];
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o   = (state_q != StIdle);
  assign done_o   = done_q;
  assign ovf_o    = ovf_q;
  assign digit1_o = dig_q[0];
  assign digit2_o = dig_q[1];
  assign digit3_o = dig_q[2];
  assign digit4_o = dig_q[3];

endmodule
